mem_stage_ex: RTL
=================

# mem_stage_ex

Parametrised pipeline memory-access stage with a sub-word load/store unit, a wait-state I/O bus with timeout, and a flushable MEM/WB register. Sits between the EX/MEM register and write-back. Extends the single-cycle memory stage with sign/zero-extended loads, misalignment trapping and pipeline stall on slow peripherals. Accesses below `IO_BASE` go to internal data memory; all others go to the I/O bus.

## Interface
- `DM_AW`, 12: data-memory word-address bits (depth 2^DM_AW words).
- `IO_BASE`, 32'h0000_3000: lowest I/O byte address, compared on `in_addr[15:0]`.
- `IO_TIMEOUT`, 15: max wait cycles for `io_ready`, ≥1.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `flush`  in  1  kill instruction currently in stage.
- `in_valid`  in  1  stage holds an instruction.
- `in_rd`, `in_wr`  in  1 each  load / store; never both.
- `in_size`  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- `in_unsigned`  in  1  zero-extend loads.
- `in_reg_write`  in  1  instruction writes a register.
- `in_rw`  in  5  destination register.
- `in_addr`  in  32  byte address (ALU result).
- `in_wdata`  in  32  store data, right-aligned.
- `stall`  out  1  upstream must hold all `in_*`.
- `io_req`, `io_we`  out  1 each  I/O request / write.
- `io_addr`  out  30  `in_addr[31:2]`.
- `io_be`  out  4  byte enables.
- `io_wdata`  out  32  lane-replicated store data.
- `io_ready`  in  1  peripheral completes this cycle.
- `io_rdata`  in  32  I/O read data, valid with `io_ready`.
- `wb_valid`, `wb_reg_write`  out  1 each  registered.
- `wb_rw`  out  5; `wb_data`  out  32  registered result.
- `wb_misalign`, `wb_buserr`  out  1 each  registered exception flags.

## Operation
- Access = `in_valid & (in_rd | in_wr)`. I/O when `in_addr[15:0] >= IO_BASE[15:0]`, else DM at word `in_addr[DM_AW+1:2]`.
- Misaligned: half with `addr[0]=1`, word with `addr[1:0]!=0`. No DM/IO activity, `wb_misalign=1`, `wb_reg_write=0`.
- Byte enables: byte `4'b0001<<addr[1:0]`; half `addr[1]?1100:0011`; word `1111`. Store data replicated: byte x4, half x2.
- Load: select lane from `addr[1:0]`, sign-extend bit 7/15 unless `in_unsigned`. Non-load result = `in_addr`.
- DM: combinational read, byte-masked write on rising edge; contents not reset.
- FSM: IDLE, IO_WAIT. In IDLE, `io_req = valid aligned I/O access & ~flush` (combinational). If `io_ready` same cycle, complete, no stall. Else go IO_WAIT, counter=1, `stall=1`.
- IO_WAIT: `io_req` held with stable outputs; `io_ready` → complete, IDLE. Counter reaches `IO_TIMEOUT` without ready → complete with `wb_buserr=1`, `wb_data=0`, `wb_reg_write=0`, IDLE.
- `stall = io_req & ~io_ready & ~timeout`.

## Timing
- Reset: all outputs 0, FSM IDLE, counter 0.
- DM and no-access instructions: 1 cycle; WB register loads on next edge.
- I/O: 1 + N cycles, N = wait cycles (≤ `IO_TIMEOUT`).
- While `stall=1`: WB register loads `wb_valid=0` bubble each edge.
- `flush` has priority over everything: DM write and `io_req` suppressed that cycle, FSM→IDLE, counter cleared, next `wb_valid=0`.
- `flush` during IO_WAIT aborts request; late `io_ready` ignored.
- Async reset mid-IO_WAIT: `io_req` drops immediately.

## Test plan
- Store word 0xDEADBEEF @0x10, load byte @0x13 signed → `wb_data=0xFFFFFFDE`; unsigned → `0x000000DE`.
- Store half 0x8001 @0x22, load half @0x22 → `0xFFFF8001`; word @0x20 shows only bytes 3:2 changed.
- Load word @0x3004, `io_ready` after 3 cycles with 0x1234 → `stall` high 3 cycles, `io_be=1111`, `wb_data=0x1234`.
- I/O load, `io_ready` never → after `IO_TIMEOUT` cycles `wb_buserr=1`, `wb_reg_write=0`, stall drops.
- Store word @0x0002 → `wb_misalign=1`, DM word 0 unchanged, `io_req=0`.
- `flush` in 2nd IO_WAIT cycle → `io_req` low, `wb_valid=0`; reset mid-wait → all outputs 0.

Source files
------------

// File: rtl/mem_stage_ex_if.sv
// -----------------------------------------------------------------------------
// mem_stage_ex_if
//   Wait-state I/O bus between the memory stage (master) and a peripheral
//   (slave).
//   io_req   : master requests a transfer; held until io_ready or abort
//   io_we    : transfer is a write
//   io_addr  : word address (byte address bits 31:2)
//   io_be    : byte enables, one per byte lane
//   io_wdata : lane-replicated write data
//   io_ready : peripheral completes the transfer this cycle
//   io_rdata : read data, valid together with io_ready
// -----------------------------------------------------------------------------
interface mem_stage_ex_if;
  logic        io_req;
  logic        io_we;
  logic [29:0] io_addr;
  logic [3:0]  io_be;
  logic [31:0] io_wdata;
  logic        io_ready;
  logic [31:0] io_rdata;

  modport master (
    output io_req, io_we, io_addr, io_be, io_wdata,
    input  io_ready, io_rdata
  );

  modport slave (
    input  io_req, io_we, io_addr, io_be, io_wdata,
    output io_ready, io_rdata
  );
endinterface

// File: rtl/mem_stage_ex.sv
// -----------------------------------------------------------------------------
// mem_stage_ex
//   Pipeline memory-access stage: sub-word loads/stores to an internal data
//   memory, wait-state I/O bus with timeout for addresses at or above IO_BASE,
//   misalignment trapping, and a flushable MEM/WB register.
//
//   clk, rst          : clock (rising edge), asynchronous active-low reset
//   flush             : kill the instruction currently in the stage
//   in_*              : instruction from EX/MEM (valid, rd, wr, size,
//                       unsigned, reg_write, rw, addr, wdata)
//   stall             : upstream must hold all in_* this cycle
//   io                : I/O bus, master side
//   wb_*              : registered MEM/WB results and exception flags
// -----------------------------------------------------------------------------
module mem_stage_ex #(
  parameter int          DM_AW      = 12,
  parameter logic [31:0] IO_BASE    = 32'h0000_3000,
  parameter int          IO_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic                  in_rd,
  input  logic                  in_wr,
  input  logic [1:0]            in_size,
  input  logic                  in_unsigned,
  input  logic                  in_reg_write,
  input  logic [4:0]            in_rw,
  input  logic [31:0]           in_addr,
  input  logic [31:0]           in_wdata,
  output logic                  stall,
  mem_stage_ex_if.master        io,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic [4:0]            wb_rw,
  output logic [31:0]           wb_data,
  output logic                  wb_misalign,
  output logic                  wb_buserr
);

  localparam int CNT_W = $clog2(IO_TIMEOUT + 1);

  typedef enum logic {
    S_IDLE,
    S_IO_WAIT
  } state_e;

  // ---------------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------------
  logic access, is_io, size_half, size_word, misalign;
  logic io_acc, dm_acc;

  assign access    = in_valid & (in_rd | in_wr);
  assign is_io     = in_addr[15:0] >= IO_BASE[15:0];
  assign size_half = (in_size == 2'b01);
  assign size_word = in_size[1];              // 11 behaves as word
  assign misalign  = access & ((size_half & in_addr[0]) |
                               (size_word & (in_addr[1:0] != 2'b00)));
  assign io_acc    = access & ~misalign & is_io;
  assign dm_acc    = access & ~misalign & ~is_io;

  // Byte enables and lane-replicated store data
  logic [3:0]  be;
  logic [31:0] wdata_rep;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned (which would infer a latch).
    be        = 4'b1111;
    wdata_rep = in_wdata;
    if (size_word) begin
      be        = 4'b1111;
      wdata_rep = in_wdata;
    end else if (size_half) begin
      be        = in_addr[1] ? 4'b1100 : 4'b0011;
      wdata_rep = {2{in_wdata[15:0]}};
    end else begin
      be        = 4'b0001 << in_addr[1:0];
      wdata_rep = {4{in_wdata[7:0]}};
    end
  end

  // ---------------------------------------------------------------------------
  // Data memory: combinational read, byte-masked synchronous write
  // ---------------------------------------------------------------------------
  logic [31:0]      dm_q [2**DM_AW];
  logic [DM_AW-1:0] dm_idx;
  logic [31:0]      dm_rdata;
  logic             dm_we;

  assign dm_idx   = in_addr[DM_AW+1:2];
  assign dm_rdata = dm_q[dm_idx];
  assign dm_we    = dm_acc & in_wr & ~flush;

  // NOTE: the storage array has no reset; clearing thousands of words would
  // force flops instead of RAM and software never relies on initial contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (dm_we && be[i]) dm_q[dm_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
    end
  end

  // ---------------------------------------------------------------------------
  // I/O wait-state FSM
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               io_req, timeout;

  // Gating with rst drops the request the moment reset asserts, even mid-wait.
  assign io_req  = rst & io_acc & ~flush;
  assign timeout = (state_q == S_IO_WAIT) && (cnt_q == CNT_W'(IO_TIMEOUT));
  assign stall   = io_req & ~io.io_ready & ~timeout;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (stall) begin
          state_d = S_IO_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      S_IO_WAIT: begin
        // Completion, timeout and flush all drop stall and return to idle.
        if (stall) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Bus outputs are zero whenever no request is active.
  assign io.io_req   = io_req;
  assign io.io_we    = io_req & in_wr;
  assign io.io_addr  = io_req ? in_addr[31:2] : '0;
  assign io.io_be    = io_req ? be : '0;
  assign io.io_wdata = io_req ? wdata_rep : '0;

  // ---------------------------------------------------------------------------
  // Load alignment and extension
  // ---------------------------------------------------------------------------
  logic [31:0] ld_word, ld_shift, ld_ext;

  assign ld_word  = is_io ? io.io_rdata : dm_rdata;
  assign ld_shift = ld_word >> {in_addr[1:0], 3'b000};

  always_comb begin
    ld_ext = ld_word;
    if (size_word)      ld_ext = ld_word;
    else if (size_half) ld_ext = {{16{~in_unsigned & ld_shift[15]}}, ld_shift[15:0]};
    else                ld_ext = {{24{~in_unsigned & ld_shift[7]}},  ld_shift[7:0]};
  end

  // ---------------------------------------------------------------------------
  // MEM/WB register: flush and stall both load an all-zero bubble
  // ---------------------------------------------------------------------------
  logic        buserr_now;
  logic        wb_valid_q,     wb_valid_d;
  logic        wb_reg_write_q, wb_reg_write_d;
  logic [4:0]  wb_rw_q,        wb_rw_d;
  logic [31:0] wb_data_q,      wb_data_d;
  logic        wb_misalign_q,  wb_misalign_d;
  logic        wb_buserr_q,    wb_buserr_d;

  assign buserr_now = io_req & timeout & ~io.io_ready;

  always_comb begin
    wb_valid_d     = 1'b0;
    wb_reg_write_d = 1'b0;
    wb_rw_d        = '0;
    wb_data_d      = '0;
    wb_misalign_d  = 1'b0;
    wb_buserr_d    = 1'b0;
    if (in_valid && !flush && !stall) begin
      wb_valid_d     = 1'b1;
      wb_reg_write_d = in_reg_write & ~misalign & ~buserr_now;
      wb_rw_d        = in_rw;
      wb_misalign_d  = misalign;
      wb_buserr_d    = buserr_now;
      if (buserr_now)              wb_data_d = '0;
      else if (in_rd && !misalign) wb_data_d = ld_ext;
      else                         wb_data_d = in_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_rw_q        <= '0;
      wb_data_q      <= '0;
      wb_misalign_q  <= 1'b0;
      wb_buserr_q    <= 1'b0;
    end else begin
      wb_valid_q     <= wb_valid_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_rw_q        <= wb_rw_d;
      wb_data_q      <= wb_data_d;
      wb_misalign_q  <= wb_misalign_d;
      wb_buserr_q    <= wb_buserr_d;
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_rw        = wb_rw_q;
  assign wb_data      = wb_data_q;
  assign wb_misalign  = wb_misalign_q;
  assign wb_buserr    = wb_buserr_q;

endmodule
